// File: rtl/arb_bus_ctrl_if.sv
// Bus bundle between the burst controller, its four masters/arbiter and the shared slave.
// The master modport is the controller's view; the slave modport is the environment's view.
interface arb_bus_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic                  gnt3;
    logic                  gnt2;
    logic                  gnt1;
    logic                  gnt0;
    logic [4*LEN_W-1:0]    m_len;
    logic [4*DATA_W-1:0]   m_data;
    logic [3:0]            m_ack;
    logic [3:0]            m_done;
    logic [3:0]            m_abort;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    logic [1:0]            s_id;
    logic                  s_last;

    modport master (
        input  gnt3, gnt2, gnt1, gnt0,
        input  m_len, m_data,
        output m_ack, m_done, m_abort,
        output s_valid, s_data, s_id, s_last,
        input  s_ready
    );

    modport slave (
        output gnt3, gnt2, gnt1, gnt0,
        output m_len, m_data,
        input  m_ack, m_done, m_abort,
        input  s_valid, s_data, s_id, s_last,
        output s_ready
    );
endinterface

// File: rtl/arb_bus_ctrl.sv
// Burst controller fed by a 4-way arbiter's registered grants: moves the granted
// master's len+1 beats onto a shared valid/ready slave bus and reports ack/done/abort.
module arb_bus_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    arb_bus_ctrl_if.master        bus,
    output logic                  busy,
    output logic                  gnt_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         id;
    logic [LEN_W-1:0]   cnt;
    logic               s_valid_q;
    logic [3:0]         done_q;
    logic [3:0]         abort_q;

    logic [3:0]         gnt;
    logic [1:0]         gnt_idx;
    logic               gnt_any;
    logic               gnt_multi;
    logic               gnt_single;
    logic               own_gnt;
    logic               beat;
    logic [LEN_W-1:0]   sel_len;

    assign gnt        = {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
    assign gnt_any    = (gnt != 4'd0);
    assign gnt_multi  = ((gnt & (gnt - 4'd1)) != 4'd0);
    assign gnt_single = gnt_any && !gnt_multi;
    assign own_gnt    = gnt[id];
    assign sel_len    = bus.m_len[int'(gnt_idx)*LEN_W +: LEN_W];

    // A beat is only taken while the owner still holds its grant; a lost grant wins.
    assign beat = (state == XFER) && own_gnt && bus.s_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (gnt[k]) gnt_idx = 2'(k);
        end
    end

    always_comb begin
        bus.m_ack = 4'd0;
        if (beat) bus.m_ack[id] = 1'b1;
    end

    assign bus.s_valid = s_valid_q;
    assign bus.s_id    = id;
    assign bus.s_data  = s_valid_q ? bus.m_data[int'(id)*DATA_W +: DATA_W] : '0;
    assign bus.s_last  = (state == XFER) && (cnt == '0);
    assign bus.m_done  = done_q;
    assign bus.m_abort = abort_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id        <= 2'd0;
            cnt       <= '0;
            s_valid_q <= 1'b0;
            busy      <= 1'b0;
            done_q    <= 4'd0;
            abort_q   <= 4'd0;
            gnt_err   <= 1'b0;
        end else begin
            done_q  <= 4'd0;
            abort_q <= 4'd0;
            if (gnt_multi) gnt_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (gnt_single) begin
                        id        <= gnt_idx;
                        cnt       <= sel_len;
                        state     <= XFER;
                        s_valid_q <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                XFER: begin
                    if (!own_gnt) begin
                        abort_q[id] <= 1'b1;
                        state       <= IDLE;
                        s_valid_q   <= 1'b0;
                        busy        <= 1'b0;
                    end else if (bus.s_ready) begin
                        if (cnt == '0) begin
                            done_q[id] <= 1'b1;
                            state      <= DONE;
                            s_valid_q  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= RELEASE;
                end

                // Hold off until the finished master's stale grant is gone.
                RELEASE: begin
                    if (!own_gnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    s_valid_q <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_bus_ctrl.sv
// Directed bench for arb_bus_ctrl: inputs change just after a rising edge, outputs
// are checked mid-cycle before the next edge.
module tb_arb_bus_ctrl;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic clk;
    logic rst;
    logic busy;
    logic gnt_err;

    int vectors;
    int miscompares;

    arb_bus_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    arb_bus_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .busy    (busy),
        .gnt_err (gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_grants();
        bus.gnt0 = 1'b0;
        bus.gnt1 = 1'b0;
        bus.gnt2 = 1'b0;
        bus.gnt3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_grants();
        bus.s_ready = 1'b0;
        bus.m_len   = '0;
        bus.m_data  = {8'h33, 8'h3C, 8'h11, 8'hA5};
        step();
        step();
        rst = 1'b0;
        settle();
        vectors++;
        if ({bus.s_valid, busy, gnt_err, bus.s_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got valid/busy/err/last=%b want 0000",
                     {bus.s_valid, busy, gnt_err, bus.s_last});
        end
        vectors++;
        if ({bus.m_ack, bus.m_done, bus.m_abort, bus.s_id} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_pulses: got ack=%b done=%b abort=%b id=%0d want all 0",
                     bus.m_ack, bus.m_done, bus.m_abort, bus.s_id);
        end
    endtask

    task automatic test_single_beat();
        bus.m_len[0*LEN_W +: LEN_W] = 4'd0;
        bus.s_ready = 1'b1;
        bus.gnt0    = 1'b1;
        step();
        settle();
        vectors++;
        if ({bus.s_valid, bus.s_data, bus.s_id, bus.s_last, bus.m_ack} !== {1'b1, 8'hA5, 2'd0, 1'b1, 4'b0001}) begin
            miscompares++;
            $display("FAIL single_beat: got valid=%b data=%h id=%0d last=%b ack=%b want 1 a5 0 1 0001",
                     bus.s_valid, bus.s_data, bus.s_id, bus.s_last, bus.m_ack);
        end
        step();
        bus.gnt0 = 1'b0;
        settle();
        vectors++;
        if ({bus.m_done, bus.s_valid, busy} !== {4'b0001, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_done: got done=%b valid=%b busy=%b want 0001 0 1",
                     bus.m_done, bus.s_valid, busy);
        end
        step();
        settle();
        vectors++;
        if ({bus.m_done, busy} !== {4'b0000, 1'b1}) begin
            miscompares++;
            $display("FAIL single_release: got done=%b busy=%b want 0000 1", bus.m_done, busy);
        end
        step();
        settle();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] pattern;
        int acks;
        pattern = 6'b101101;
        acks = 0;
        bus.m_len[2*LEN_W +: LEN_W] = 4'd3;
        bus.s_ready = 1'b0;
        bus.gnt2    = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            bus.s_ready = pattern[5-i];
            settle();
            vectors++;
            if ({bus.s_valid, bus.s_data, bus.s_id, bus.s_last, bus.m_ack} !==
                {1'b1, 8'h3C, 2'd2, (acks == 3), (pattern[5-i] ? 4'b0100 : 4'b0000)}) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got valid=%b data=%h id=%0d last=%b ack=%b want 1 3c 2 %b %b",
                         i, bus.s_valid, bus.s_data, bus.s_id, bus.s_last, bus.m_ack,
                         (acks == 3), (pattern[5-i] ? 4'b0100 : 4'b0000));
            end
            if (bus.m_ack[2]) acks++;
            step();
        end
        bus.s_ready = 1'b0;
        bus.gnt2    = 1'b0;
        settle();
        vectors++;
        if ({bus.m_done, bus.s_valid} !== {4'b0100, 1'b0} || acks != 4) begin
            miscompares++;
            $display("FAIL bp_done: got done=%b valid=%b acks=%0d want 0100 0 4",
                     bus.m_done, bus.s_valid, acks);
        end
        step();
        step();
        settle();
        vectors++;
        if ({bus.m_done, busy} !== 5'b00000) begin
            miscompares++;
            $display("FAIL bp_idle: got done=%b busy=%b want 0000 0", bus.m_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id [5];
        exp_id = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
        bus.m_len[1*LEN_W +: LEN_W] = 4'd1;
        bus.m_len[3*LEN_W +: LEN_W] = 4'd2;
        bus.s_ready = 1'b1;
        bus.gnt1    = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if ({bus.s_valid, bus.s_id, bus.s_data, bus.m_ack} !== {1'b1, exp_id[i], 8'h11, 4'b0010}) begin
                miscompares++;
                $display("FAIL b2b_m1_beat%0d: got valid=%b id=%0d data=%h ack=%b want 1 %0d 11 0010",
                         i, bus.s_valid, bus.s_id, bus.s_data, bus.m_ack, exp_id[i]);
            end
            step();
        end
        settle();
        vectors++;
        if ({bus.m_done, bus.s_valid} !== {4'b0010, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_m1_done: got done=%b valid=%b want 0010 0", bus.m_done, bus.s_valid);
        end
        step();
        settle();
        vectors++;
        if ({busy, bus.s_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_hold: got busy=%b valid=%b want 1 0", busy, bus.s_valid);
        end
        step();
        bus.gnt1 = 1'b0;
        bus.gnt3 = 1'b1;
        settle();
        vectors++;
        if ({busy, bus.s_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_release: got busy=%b valid=%b want 1 0", busy, bus.s_valid);
        end
        step();
        settle();
        vectors++;
        if ({busy, bus.s_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_gap: got busy=%b valid=%b want 0 0", busy, bus.s_valid);
        end
        step();
        for (int i = 2; i < 5; i++) begin
            settle();
            vectors++;
            if ({bus.s_valid, bus.s_id, bus.s_data, bus.s_last, bus.m_ack} !==
                {1'b1, exp_id[i], 8'h33, (i == 4), 4'b1000}) begin
                miscompares++;
                $display("FAIL b2b_m3_beat%0d: got valid=%b id=%0d data=%h last=%b ack=%b want 1 %0d 33 %b 1000",
                         i, bus.s_valid, bus.s_id, bus.s_data, bus.s_last, bus.m_ack, exp_id[i], (i == 4));
            end
            step();
        end
        bus.gnt3 = 1'b0;
        settle();
        vectors++;
        if ({bus.m_done, gnt_err} !== {4'b1000, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_m3_done: got done=%b err=%b want 1000 0", bus.m_done, gnt_err);
        end
        step();
        step();
    endtask

    task automatic test_abort();
        bus.m_len[3*LEN_W +: LEN_W] = 4'd7;
        bus.s_ready = 1'b1;
        bus.gnt3    = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if (bus.m_ack !== 4'b1000) begin
                miscompares++;
                $display("FAIL abort_beat%0d: got ack=%b want 1000", i, bus.m_ack);
            end
            step();
        end
        bus.gnt3 = 1'b0;
        settle();
        vectors++;
        if ({bus.s_valid, bus.m_ack} !== {1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL abort_lost: got valid=%b ack=%b want 1 0000", bus.s_valid, bus.m_ack);
        end
        step();
        settle();
        vectors++;
        if ({bus.m_abort, bus.m_done, bus.s_valid, busy} !== {4'b1000, 4'b0000, 2'b00}) begin
            miscompares++;
            $display("FAIL abort_pulse: got abort=%b done=%b valid=%b busy=%b want 1000 0000 0 0",
                     bus.m_abort, bus.m_done, bus.s_valid, busy);
        end
        step();
        settle();
        vectors++;
        if ({bus.m_abort, bus.m_done} !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_after: got abort=%b done=%b want 0000 0000", bus.m_abort, bus.m_done);
        end
    endtask

    task automatic test_illegal_grant();
        bus.s_ready = 1'b1;
        bus.gnt0    = 1'b1;
        bus.gnt1    = 1'b1;
        step();
        settle();
        vectors++;
        if ({gnt_err, bus.s_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL illegal_set: got err=%b valid=%b busy=%b want 1 0 0", gnt_err, bus.s_valid, busy);
        end
        step();
        clear_grants();
        settle();
        vectors++;
        if ({gnt_err, bus.s_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL illegal_hold: got err=%b valid=%b want 1 0", gnt_err, bus.s_valid);
        end
        step();
        step();
        settle();
        vectors++;
        if (gnt_err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_sticky: got err=%b want 1", gnt_err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        vectors++;
        if (gnt_err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: got err=%b want 0", gnt_err);
        end
    endtask

    task automatic test_mid_reset();
        bus.m_len[0*LEN_W +: LEN_W] = 4'd5;
        bus.s_ready = 1'b1;
        bus.gnt0    = 1'b1;
        step();
        step();
        rst = 1'b1;
        settle();
        vectors++;
        if ({bus.s_valid, bus.m_ack} !== {1'b1, 4'b0001}) begin
            miscompares++;
            $display("FAIL midrst_beat2: got valid=%b ack=%b want 1 0001", bus.s_valid, bus.m_ack);
        end
        step();
        settle();
        vectors++;
        if ({bus.s_valid, busy, bus.s_last, bus.m_ack, bus.m_done, bus.m_abort, bus.s_id} !== 17'd0) begin
            miscompares++;
            $display("FAIL midrst_out: got valid=%b busy=%b last=%b ack=%b done=%b abort=%b id=%0d want all 0",
                     bus.s_valid, busy, bus.s_last, bus.m_ack, bus.m_done, bus.m_abort, bus.s_id);
        end
        rst = 1'b0;
        clear_grants();
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_illegal_grant();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
